seven_segment_arbiter: RTL and testbench
========================================

# seven_segment_arbiter

- Time-multiplexes the single 8-digit seven-segment driver between several independent content sources: status counter, key echo, error code, etc.
- Each requester presents a full `number`/`dots` image plus a request bit.
- The arbiter grants one requester at a time in round-robin order, for a programmable number of slow ticks.
- Its registered `number`/`dots` outputs feed `seven_segment_display` directly, inside `hackathon_top`.

## Interface
Parameters:
- `n_req`, 4: number of requesters (2..8).
- `w_digit`, 8: display digits; image width is `w_digit*4` bits.
- `w_dwell`, 8: width of the dwell-time input.
- `w_div`, 22: slow-tick divider width; tick period is `2**w_div` clocks.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: reset is synchronous and active-high.
- `req` in `n_req`: per-requester display request, level-sensitive.
- `number_in` in `n_req*w_digit*4`: flattened images; requester i occupies `[i*w_digit*4 +: w_digit*4]`.
- `dots_in` in `n_req*w_digit`: flattened dots; requester i occupies `[i*w_digit +: w_digit]`.
- `dwell` in `w_dwell`: slot length in ticks; value 0 is treated as 1; sampled at each slot start.
- `grant` out `n_req`: one-hot current owner; all zero when idle.
- `number` out `w_digit*4`: image to the display driver.
- `dots` out `w_digit`: dots to the display driver.
- `busy` out 1: high while a requester owns the display.
- `tick` out 1: one-clock slow-tick pulse, exported for animation logic.

## Operation
**Divider**
- Free-running `div_cnt`, `w_div` bits, reset to 0.
- `tick` = (`div_cnt` == all-ones), combinational from the register.

**FSM: IDLE, SHOW**
- Round-robin pointer `last`, reset to `n_req-1`, so requester 0 wins first.
- Arbitration picks the lowest index strictly after `last` (cyclic) whose `req` is high.

**IDLE**
- `grant`=0, `number`=0, `dots`=0, `busy`=0.
- Any `req` high → arbitrate → SHOW.
- On entry to SHOW: `grant` = winner; `last` = winner; `dwell_cnt` <= max(`dwell`,1).

**SHOW**
- Every cycle, `number`/`dots` register the granted requester's live `number_in`/`dots_in` slice.
- Content changes from the owner pass through with 1-cycle latency.
- On `tick`: if `dwell_cnt` > 1, decrement; if `dwell_cnt` == 1, the slot expires.
- On slot expiry: re-arbitrate from `last`.
  - If another requester is pending, switch to it and reload `dwell_cnt`.
  - If only the current owner requests, it keeps the grant and `dwell_cnt` reloads.
  - If none request, go to IDLE.
- Owner drops `req`, any cycle: re-arbitrate in that same cycle. Switch to the next pending requester, or go to IDLE. No blank cycle when switching.
- Simultaneous owner drop and slot expiry: handled as owner drop (identical result).
- Non-owner `req` changes never affect the current slot.

**Output update rule**
- `number`/`dots`/`grant` load from the next-state owner, so grant and content always change in the same clock.
- On any transition to IDLE, `number`/`dots` clear to 0.

## Timing
- Reset: `grant`=0, `number`=0, `dots`=0, `busy`=0, `tick`=0, `div_cnt`=0, `last`=`n_req-1`, FSM=IDLE.
- Reset mid-slot wins unconditionally: the next cycle shows all outputs at reset values.
- `req` high at cycle N in IDLE → `grant`, `busy`, `number`, `dots` valid at N+1.
- Owner `req` low at cycle N → new owner (or IDLE) at N+1.
- Owner image change at N → `number` changes at N+1.
- A slot lasts between (`dwell`-1) and `dwell` full tick periods; the first period is partial.

## Configuration
Macro: `SEVEN_SEGMENT_ARBITER_PREEMPT_EN`.
- Defined:
  - Requester 0 is high-priority. `req[0]` high while another requester owns SHOW → requester 0 is granted at the next cycle with a fresh `dwell_cnt`.
  - `last` becomes 0, so the round-robin order resumes after 0.
  - While requester 0 owns the display, its slot never expires while other requests are pending. It keeps ownership until it drops `req[0]`.
- Undefined: requester 0 is an ordinary round-robin participant; no preemption logic is synthesized.

## Test plan
Use `n_req`=4, `w_div`=2 (tick every 4 clocks) unless stated.
- **Reset/idle:** after reset with `req`=0 for 20 clocks → `grant`=0, `number`=0, `busy`=0; `tick` pulses every 4th clock.
- **Single requester:** `req`=0001, `number_in[31:0]`=32'hDEAD_BEEF, `dots_in[7:0]`=8'hA5 → one clock later `grant`=0001, `number`=DEADBEEF, `dots`=A5. Change the image to 32'h0000_0001 → `number` follows one clock later.
- **Round-robin:** `req`=1111, `dwell`=2 → `grant` sequence 0001, 0010, 0100, 1000, 0001. Each switch occurs exactly on a tick clock, each slot spans 1–2 tick periods, and `number` matches the owner's slice.
- **Owner drop:** `req`=0101, owner 0 drops `req[0]` mid-slot → next clock `grant`=0100 with no zero gap. Then `req`=0000 → next clock IDLE, `number`=0.
- **Dwell 0 / reload:** `dwell`=0, `req`=0010 only → grant held at 0010, reloaded on every tick, no glitch on `number`.
- **Preempt (macro defined):** requester 2 owns the display, `req[0]` rises at cycle N → `grant`=0001 at N+1. With the macro undefined, the same stimulus keeps `grant`=0100 until slot expiry.

Source files
------------

// File: rtl/seven_segment_arbiter.sv
// seven_segment_arbiter: round-robin time-multiplexing of several number/dots images onto one display.
// Optional requester-0 preemption via SEVEN_SEGMENT_ARBITER_PREEMPT_EN.
module seven_segment_arbiter #(
  parameter int n_req   = 4,
  parameter int w_digit = 8,
  parameter int w_dwell = 8,
  parameter int w_div   = 22
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [n_req-1:0]             req,
  input  logic [n_req*w_digit*4-1:0]   number_in,
  input  logic [n_req*w_digit-1:0]     dots_in,
  input  logic [w_dwell-1:0]           dwell,
  output logic [n_req-1:0]             grant,
  output logic [w_digit*4-1:0]         number,
  output logic [w_digit-1:0]           dots,
  output logic                         busy,
  output logic                         tick
);
  localparam int W_IDX = $clog2(n_req);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;
  logic [0:0]           state_q, state_d;
  logic [W_IDX-1:0]     last_q, last_d, win, nxt, idx;
  logic [w_dwell-1:0]   dwell_cnt_q, dwell_cnt_d, dwell_ld;
  logic [w_div-1:0]     div_q, div_d;
  logic [w_digit*4-1:0] number_q, number_d;
  logic [w_digit-1:0]   dots_q, dots_d;
  logic                 found, take, pre, hold, expire;
`ifdef SEVEN_SEGMENT_ARBITER_PREEMPT_EN
  assign pre  = req[0] && last_q != '0;
  assign hold = last_q == '0 && |req[n_req-1:1];
`else
  assign pre  = 1'b0;
  assign hold = 1'b0;
`endif
  assign tick     = &div_q;
  assign div_d    = div_q + w_div'(1);
  assign dwell_ld = (dwell == '0) ? w_dwell'(1) : dwell;
  assign expire   = tick && dwell_cnt_q == w_dwell'(1) && !hold;
  assign busy     = state_q == SHOW;
  assign grant    = busy ? (n_req'(1) << last_q) : '0;
  assign number   = number_q;
  assign dots     = dots_q;
  always_comb begin
    win = last_q;
    found = 1'b0;
    idx = '0;
    // descending offset so the nearest pending requester after last wins
    for (int k = n_req; k >= 1; k--) begin
      idx = W_IDX'((int'(last_q) + k) % n_req);
      if (req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
    state_d = state_q;
    last_d = last_q;
    dwell_cnt_d = dwell_cnt_q;
    take = 1'b0;
    nxt = win;
    if (state_q == IDLE) take = found;
    else if (pre) begin
      take = 1'b1;
      nxt = '0;
    end else if (!req[last_q] || expire) begin
      take = found;
      state_d = found ? SHOW : IDLE;
    end else if (tick && dwell_cnt_q > w_dwell'(1)) dwell_cnt_d = dwell_cnt_q - w_dwell'(1);
    if (take) begin
      state_d = SHOW;
      last_d = nxt;
      dwell_cnt_d = dwell_ld;
    end
    number_d = (state_d == SHOW) ? number_in[last_d*w_digit*4 +: w_digit*4] : '0;
    dots_d = (state_d == SHOW) ? dots_in[last_d*w_digit +: w_digit] : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= W_IDX'(n_req - 1);
      dwell_cnt_q <= '0;
      div_q <= '0;
      number_q <= '0;
      dots_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      dwell_cnt_q <= dwell_cnt_d;
      div_q <= div_d;
      number_q <= number_d;
      dots_q <= dots_d;
    end
  end
endmodule

// File: tb/tb_seven_segment_arbiter.sv
// tb_seven_segment_arbiter: vector table, corner sequences and random run against a behavioural model.
module tb_seven_segment_arbiter;
  localparam int NR = 4;
  localparam int WD = 8;
  localparam int WW = 8;
  localparam int WV = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*WD*4-1:0] number_in;
  logic [NR*WD-1:0] dots_in;
  logic [WW-1:0] dwell = 8'd8;
  logic [NR-1:0] grant;
  logic [WD*4-1:0] number;
  logic [WD-1:0] dots;
  logic busy, tick;
  seven_segment_arbiter #(.n_req(NR), .w_digit(WD), .w_dwell(WW), .w_div(WV)) dut (
    .clock(clock), .reset(reset), .req(req), .number_in(number_in), .dots_in(dots_in),
    .dwell(dwell), .grant(grant), .number(number), .dots(dots), .busy(busy), .tick(tick));
  always #5 clock = ~clock;
  int total = 0;
  int bad = 0;
  int m_div = 0, m_own = -1, m_last = NR - 1, m_cnt = 0;
  logic [31:0] m_num = 0;
  logic [7:0] m_dots = 0;
  typedef struct {
    logic [3:0] rq; logic [31:0] n0; logic [7:0] d0;
    logic [3:0] eg; logic [31:0] en; logic [7:0] ed; logic eb;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int pick(input int after);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (after + k) % NR;
      if (req[i]) return i;
    end
    return -1;
  endfunction
  task automatic start(input int o);
    m_own = o;
    m_last = o;
    m_cnt = (dwell == 0) ? 1 : int'(dwell);
  endtask
  task automatic model();
    bit tk, pre, hold;
    int o;
    tk = (m_div == 2**WV - 1);
    pre = 0;
    hold = 0;
`ifdef SEVEN_SEGMENT_ARBITER_PREEMPT_EN
    pre = m_own > 0 && req[0];
    hold = m_own == 0 && req[NR-1:1] != 0;
`endif
    if (reset) begin
      m_div = 0; m_own = -1; m_last = NR - 1; m_cnt = 0;
    end else begin
      if (m_own < 0) begin
        if (req != 0) start(pick(m_last));
      end else if (pre) start(0);
      else if (!req[m_own] || (tk && m_cnt == 1 && !hold)) begin
        o = pick(m_own);
        if (o < 0) m_own = -1;
        else start(o);
      end else if (tk && m_cnt > 1) m_cnt--;
      m_div = (m_div + 1) % (2**WV);
    end
    m_num = 0;
    m_dots = 0;
    if (m_own >= 0 && !reset) begin
      m_num = number_in[m_own*32 +: 32];
      m_dots = dots_in[m_own*8 +: 8];
    end
  endtask
  task automatic step();
    logic [3:0] eg;
    @(posedge clock);
    model();
    #1;
    eg = (m_own < 0) ? 4'b0 : 4'(1 << m_own);
    chk("m_grant", 32'(grant), 32'(eg));
    chk("m_number", number, m_num);
    chk("m_dots", 32'(dots), 32'(m_dots));
    chk("m_busy", 32'(busy), 32'(m_own >= 0));
    chk("m_tick", 32'(tick), 32'(m_div == 2**WV - 1));
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  initial begin
    logic [3:0] seq[5];
    logic [3:0] prev, expg;
    logic pt;
    int got, since, ticks;
    for (int i = 0; i < NR; i++) begin
      number_in[i*32 +: 32] = 32'h1111_1111 * (i + 1);
      dots_in[i*8 +: 8] = 8'h11 * (i + 1);
    end
    vt[0] = '{4'b0000, 32'h0, 8'h0, 4'b0000, 32'h0, 8'h0, 1'b0};
    vt[1] = '{4'b0001, 32'hDEAD_BEEF, 8'hA5, 4'b0001, 32'hDEAD_BEEF, 8'hA5, 1'b1};
    vt[2] = '{4'b0001, 32'h0000_0001, 8'hA5, 4'b0001, 32'h0000_0001, 8'hA5, 1'b1};
    vt[3] = '{4'b0101, 32'h0000_0001, 8'h5A, 4'b0001, 32'h0000_0001, 8'h5A, 1'b1};
    vt[4] = '{4'b0100, 32'h0000_0001, 8'h5A, 4'b0100, 32'h3333_3333, 8'h33, 1'b1};
    vt[5] = '{4'b0000, 32'h0000_0001, 8'h5A, 4'b0000, 32'h0, 8'h0, 1'b0};
    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_number", number, 0);
    chk("rst_dots", 32'(dots), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(tick), 0);
    ticks = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      ticks += int'(tick);
      chk("idle_busy", 32'(busy), 0);
    end
    chk("idle_ticks", ticks, 5);
    for (int v = 0; v < 6; v++) begin
      req = vt[v].rq;
      number_in[31:0] = vt[v].n0;
      dots_in[7:0] = vt[v].d0;
      step();
      chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(vt[v].eg));
      chk($sformatf("vec%0d_number", v), number, vt[v].en);
      chk($sformatf("vec%0d_dots", v), 32'(dots), 32'(vt[v].ed));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vt[v].eb));
    end
`ifdef SEVEN_SEGMENT_ARBITER_PREEMPT_EN
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100};
    do_reset();
    req = 4'b1110;
`else
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
`endif
    dwell = 2;
    got = 0;
    since = 0;
    prev = grant;
    for (int c = 0; c < 200 && got < 5; c++) begin
      pt = tick;
      step();
      since++;
      if (grant !== prev) begin
        chk("rr_grant", 32'(grant), 32'(seq[got]));
        if (got > 0) chk("rr_on_tick", 32'(pt), 1);
        if (got == 1) chk("rr_first_len", 32'(since >= 5 && since <= 8), 1);
        if (got > 1) chk("rr_len", since, 8);
        chk("rr_number", number, number_in[($clog2(int'(grant)))*32 +: 32]);
        got++;
        prev = grant;
        since = 0;
      end
    end
    chk("rr_switches", got, 5);
    do_reset();
    dwell = 8;
    req = 4'b0101;
    step();
    step();
    chk("drop_own0", 32'(grant), 32'(4'b0001));
    req = 4'b0100;
    step();
    chk("drop_grant", 32'(grant), 32'(4'b0100));
    chk("drop_number", number, number_in[95:64]);
    req = 4'b0000;
    step();
    chk("drop_idle", 32'(busy), 0);
    chk("drop_num0", number, 0);
    dwell = 0;
    req = 4'b0010;
    for (int c = 0; c < 40; c++) begin
      step();
      chk("dw0_grant", 32'(grant), 32'(4'b0010));
      chk("dw0_number", number, number_in[63:32]);
    end
    do_reset();
    dwell = 8;
    req = 4'b0100;
    step();
    chk("pre_own2", 32'(grant), 32'(4'b0100));
    req = 4'b0101;
`ifdef SEVEN_SEGMENT_ARBITER_PREEMPT_EN
    expg = 4'b0001;
`else
    expg = 4'b0100;
`endif
    for (int c = 0; c < 4; c++) begin
      step();
      chk("pre_grant", 32'(grant), 32'(expg));
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_number", number, 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_tick", 32'(tick), 0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) dwell = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        number_in = {$urandom, $urandom, $urandom, $urandom};
        dots_in = $urandom;
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
